// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the FIFO-fed UART transmitter: frame geometry,
//   serial line levels and the transmitter state encoding.
//
//   Build option: define UART_TX_PARITY_EN to add the PARITY state (8E1).
//   Without the macro the frame is 8N1/8N2 and PARITY does not exist.
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // Explicit encodings keep state values stable between the two builds.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd5,
`endif
        STOP   = 3'd6
    } tx_state_t;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// ----------------------------------------------------------------------------
// fifo_uart_tx_if
//   Read-side handshake between the 8-bit synchronous FIFO and its consumer.
//
//   Signals:
//     empty      FIFO empty flag (driven by the FIFO)
//     fifo_data  FIFO registered d_out, valid the cycle after read
//     read       one-cycle pop strobe (driven by the consumer)
//
//   Modports:
//     master  consumer side (the UART transmitter)
//     slave   FIFO side
// ----------------------------------------------------------------------------
interface fifo_uart_tx_if import uart_pkg::*; ();

    logic                 empty;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 read;

    modport master (
        input  empty,
        input  fifo_data,
        output read
    );

    modport slave (
        output empty,
        output fifo_data,
        input  read
    );

endinterface

// File: rtl/baud_tick_gen.sv
// ----------------------------------------------------------------------------
// baud_tick_gen
//   Free-running bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps,
//   raising tick for one cycle at the terminal count.
//
//   Parameters:
//     CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//
//   Ports:
//     clk    system clock, rising edge
//     rst    asynchronous active-low reset
//     clear  synchronous clear; holds the count at 0 while high
//     tick   one-cycle pulse on the last cycle of each bit period
// ----------------------------------------------------------------------------
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    // CLKS_PER_BIT-1 always fits in $clog2(CLKS_PER_BIT) bits, so the
    // counter never needs to hold a value past its terminal count.
    localparam int               CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// ----------------------------------------------------------------------------
// fifo_uart_tx
//   Pops bytes from an 8-bit synchronous FIFO and serialises them LSB first
//   as 8N1 / 8N2 frames on a registered, glitch-free tx line.
//
//   Build option: define UART_TX_PARITY_EN to send an even-parity bit
//   between data bit 7 and the first stop bit (8E1 / 8E2).
//
//   Parameters:
//     CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//     STOP_BITS     number of stop bits (1 or 2)
//
//   Ports:
//     clk      system clock, rising edge
//     rst      asynchronous active-low reset
//     fifo     FIFO read handshake (master modport: empty, fifo_data, read)
//     tx       serial output, idle high
//     busy     high in every state except IDLE
//     tx_done  one-cycle pulse on the final stop-bit cycle
// ----------------------------------------------------------------------------
module fifo_uart_tx import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic           clk,
    input  logic           rst,
    fifo_uart_tx_if.master fifo,
    output logic           tx,
    output logic           busy,
    output logic           tx_done
);

    localparam int               IDX_W     = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t            state;
    logic [DATA_BITS-1:0] shreg;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
`ifdef UART_TX_PARITY_EN
    logic                 parity;
`endif

    logic tick;
    logic baud_clear;

    // Hold the bit timer at zero until the frame starts so START always
    // lasts exactly CLKS_PER_BIT cycles.
    assign baud_clear = (state == IDLE) || (state == FETCH) || (state == LOAD);

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (baud_clear),
        .tick  (tick)
    );

    // The pop is qualified by empty in the same cycle, so a FIFO that drains
    // between the IDLE check and FETCH is never popped.
    assign fifo.read = (state == FETCH) && !fifo.empty;
    assign busy      = (state != IDLE);
    assign tx_done   = (state == STOP) && tick && (stop_idx == LAST_STOP);

    // tx is updated on the edge that enters each bit, so the level seen on
    // the line always belongs to the current state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tx       <= LINE_IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx <= LINE_IDLE;
                    if (!fifo.empty) begin
                        state <= FETCH;
                    end
                end

                FETCH: begin
                    state <= fifo.empty ? IDLE : LOAD;
                end

                // fifo_data is the FIFO's registered output for the pop
                // issued in FETCH.
                LOAD: begin
                    shreg    <= fifo.fifo_data;
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity   <= 1'b0;
`endif
                    tx       <= LINE_START;
                    state    <= START;
                end

                START: begin
                    if (tick) begin
                        tx    <= shreg[0];
                        state <= DATA;
                    end
                end

                // shreg[0] is always the bit currently on the line.
                DATA: begin
                    if (tick) begin
`ifdef UART_TX_PARITY_EN
                        parity <= parity ^ shreg[0];
`endif
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity ^ shreg[0];
                            state <= PARITY;
`else
                            tx    <= LINE_IDLE;
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        tx    <= LINE_IDLE;
                        state <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (tick) begin
                        if (stop_idx == LAST_STOP) begin
                            state <= IDLE;
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end
                end

                default: begin
                    tx    <= LINE_IDLE;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_fifo_uart_tx
//   Two transmitters at CLKS_PER_BIT=4 (STOP_BITS=1 and STOP_BITS=2) share
//   one behavioural FIFO; sel chooses which one sees the FIFO as non-empty.
//   Stimulus queues expected frames in a scoreboard; a negedge monitor pops
//   an entry whenever a start bit appears and checks every cycle of the frame.
// ----------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_uart_tx_if bus1 ();
    fifo_uart_tx_if bus2 ();

    logic tx1, busy1, done1;
    logic tx2, busy2, done2;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .fifo    (bus1),
        .tx      (tx1),
        .busy    (busy1),
        .tx_done (done1)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk     (clk),
        .rst     (rst),
        .fifo    (bus2),
        .tx      (tx2),
        .busy    (busy2),
        .tx_done (done2)
    );

    // ---------------- behavioural FIFO ----------------
    logic [7:0] fmem [16];
    int         push_cnt = 0;
    int         pop_cnt  = 0;
    logic [7:0] fdata    = 8'h00;
    logic       sel      = 1'b0;

    wire fempty = (push_cnt == pop_cnt);
    wire read_m = bus1.read | bus2.read;
    wire tx_m   = sel ? tx2   : tx1;
    wire busy_m = sel ? busy2 : busy1;
    wire done_m = sel ? done2 : done1;

    assign bus1.empty     = sel ? 1'b1 : fempty;
    assign bus2.empty     = sel ? fempty : 1'b1;
    assign bus1.fifo_data = fdata;
    assign bus2.fifo_data = fdata;

    always @(posedge clk) begin
        if (read_m) begin
            fdata   <= fmem[pop_cnt[3:0]];
            pop_cnt <= pop_cnt + 1;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;    // hand-computed even parity
        int         stops;
        int         gap;    // required idle cycles before start, -1 = any
    } exp_t;

    exp_t sb[$];

    task automatic push_byte(input logic [7:0] b, input logic p, input int stops, input int gap);
        exp_t e;
        fmem[push_cnt[3:0]] = b;
        push_cnt = push_cnt + 1;
        e.data  = b;
        e.par   = p;
        e.stops = stops;
        e.gap   = gap;
        sb.push_back(e);
    endtask

    logic        mon_en   = 1'b1;
    bit          in_frame = 1'b0;
    bit          bogus    = 1'b0;
    int          cyc      = 0;
    int          gap      = -1;
    int          nbits    = 10;
    logic [15:0] lv       = '1;
    exp_t        cur;
    int          n_reads  = 0;
    int          n_done   = 0;

    always @(negedge clk) begin
        if (rst) begin
            n_reads += int'(bus1.read) + int'(bus2.read);
            n_done  += int'(done1) + int'(done2);
            check("read_while_empty",
                  int'((bus1.read & bus1.empty) | (bus2.read & bus2.empty)), 0);
        end
        if (!rst || !mon_en) begin
            in_frame = 1'b0;
            gap      = -1;
        end else begin
            if (!in_frame && tx_m == 1'b0) begin
                if (sb.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                    bogus = 1'b1;
                    nbits = 10;
                end else begin
                    cur = sb.pop_front();
                    lv  = '1;
                    lv[0] = 1'b0;
                    for (int i = 0; i < 8; i++) lv[1+i] = cur.data[i];
                    nbits = 9;
`ifdef UART_TX_PARITY_EN
                    lv[9] = cur.par;
                    nbits = 10;
`endif
                    nbits += cur.stops;
                    if (cur.gap >= 0) check("gap_before_start", gap, cur.gap);
                end
                in_frame = 1'b1;
                cyc      = 0;
            end
            if (in_frame) begin
                if (!bogus) begin
                    check("tx_level", int'(tx_m), int'(lv[cyc / CPB]));
                    check("tx_done", int'(done_m), int'(cyc == nbits * CPB - 1));
                    check("busy_in_frame", int'(busy_m), 1);
                end
                cyc++;
                if (cyc == nbits * CPB) begin
                    in_frame = 1'b0;
                    bogus    = 1'b0;
                    gap      = 0;
                end
            end else if (gap >= 0) begin
                gap++;
            end
        end
    end

    task automatic wait_idle(input int budget);
        int k = 0;
        while (!(sb.size() == 0 && !in_frame && !busy_m && fempty) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_idle_timeout", int'(k >= budget), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", int'({tx1, tx2}), 3);
        check("reset_busy", int'({busy1, busy2}), 0);
        check("reset_done", int'({done1, done2}), 0);
        rst = 1'b1;

        // Idle with empty held: line high, no pops, not busy.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_tx", int'({tx1, tx2}), 3);
            check("idle_read", int'({bus1.read, bus2.read}), 0);
            check("idle_busy", int'({busy1, busy2}), 0);
        end

        // 0xA5: empty falls in cycle N -> read N+1, capture N+2, tx low N+3.
        @(negedge clk);
        push_byte(8'hA5, 1'b0, 1, -1);
        @(negedge clk);
        check("read_n1", int'(bus1.read), 1);
        @(negedge clk);
        check("read_n2", int'(bus1.read), 0);
        check("tx_high_n2", int'(tx1), 1);
        @(negedge clk);
        check("tx_low_n3", int'(tx1), 0);
        wait_idle(300);

        // 0x3C then 0xFF back-to-back: second start after exactly 3 idle cycles.
        @(negedge clk);
        push_byte(8'h3C, 1'b0, 1, -1);
        push_byte(8'hFF, 1'b0, 1, 3);
        wait_idle(600);

        // 0x01: single one bit, odd weight.
        @(negedge clk);
        push_byte(8'h01, 1'b1, 1, -1);
        wait_idle(300);

        // Two stop bits: stop high for 8 cycles, tx_done on the 8th.
        @(negedge clk);
        sel = 1'b1;
        @(negedge clk);
        push_byte(8'hA5, 1'b0, 2, -1);
        wait_idle(300);
        sel = 1'b0;

        // Reset in DATA bit 3 of 0x55: line returns high at once, no re-read.
        mon_en = 1'b0;
        @(negedge clk);
        fmem[push_cnt[3:0]] = 8'h55;
        push_cnt = push_cnt + 1;
        k = 0;
        while (tx1 !== 1'b0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("rst_start_seen", int'(tx1), 0);
        repeat (CPB * 4 + 1) @(negedge clk);
        check("rst_bit3_level", int'(tx1), 0);
        check("rst_busy_before", int'(busy1), 1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_tx_async", int'(tx1), 1);
        check("rst_busy_async", int'(busy1), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("post_rst_read", int'(bus1.read), 0);
            check("post_rst_tx", int'(tx1), 1);
        end

        check("read_pulses", n_reads, 6);
        check("done_pulses", n_done, 5);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
